// File: rtl/shift_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_feed_ctrl
// Purpose  : Accepts a word over valid/ready and serializes it, one bit per
//            clock, onto the serial/direction inputs of a shift register.
// Revision : 1.0  initial release
// ============================================================================
module shift_feed_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_right,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_d,
    output logic             o_right,
    output logic             o_shift_en,
    output logic             o_busy,
    output logic             o_done
);

    localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_gap_w-1:0] c_last_gap = c_gap_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_word;
    logic [c_cnt_w-1:0] r_bit_cnt;
    logic [c_gap_w-1:0] r_gap_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            o_ready    <= 1'b1;
            o_d        <= 1'b0;
            o_right    <= 1'b1;
            o_shift_en <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid && o_ready) begin
                        // First bit goes out directly; the held copy is pre-shifted
                        // so the next bit always sits at the same end.
                        o_d        <= i_right ? i_data[0] : i_data[WIDTH-1];
                        r_word     <= i_right ? (i_data >> 1) : (i_data << 1);
                        o_right    <= i_right;
                        o_shift_en <= 1'b1;
                        o_busy     <= 1'b1;
                        o_ready    <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == c_last_bit) begin
                        o_d        <= 1'b0;
                        o_shift_en <= 1'b0;
                        o_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        o_d       <= o_right ? r_word[0] : r_word[WIDTH-1];
                        r_word    <= o_right ? (r_word >> 1) : (r_word << 1);
                    end
                end
                S_DONE: begin
                    o_done <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == c_last_gap) begin
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
